// File: rtl/store_router_if.sv
// store_router_if: store request, target and drop-flag signals of the store router
interface store_router_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic [2:0]  tgt_valid;
  logic [2:0]  tgt_ready;
  logic [31:0] tgt_addr;
  logic [31:0] tgt_wdata;
  logic [3:0]  tgt_be;
  logic        err_pulse;
  logic [31:0] err_addr;
  logic [7:0]  err_count;
  modport master (
    output req_valid, req_addr, req_wdata, req_be, tgt_ready,
    input  req_ready, tgt_valid, tgt_addr, tgt_wdata, tgt_be, err_pulse, err_addr, err_count
  );
  modport slave (
    input  req_valid, req_addr, req_wdata, req_be, tgt_ready,
    output req_ready, tgt_valid, tgt_addr, tgt_wdata, tgt_be, err_pulse, err_addr, err_count
  );
endinterface

// File: rtl/store_router.sv
// store_router: one-entry store demux to DM/timer0/timer1, drops flagged; STORE_ROUTER_ERRCNT_EN adds a saturating drop counter
module store_router (
  input logic           clk,
  input logic           reset,
  store_router_if.slave bus
);
  localparam logic [31:0] DM_LIMIT  = 32'h0000_3000;
  localparam logic [31:0] DEV0_BASE = 32'h0000_7F00;
  localparam logic [31:0] DEV1_BASE = 32'h0000_7F10;
  typedef enum logic {EMPTY, FULL} state_t;
  state_t      state_q, state_d;
  logic [2:0]  tgt_valid_q, tgt_valid_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, err_addr_q, err_addr_d;
  logic [3:0]  be_q, be_d;
  logic        err_pulse_q, err_pulse_d;
  logic        be_ok, fire, accept, load;
  logic [2:0]  dec;
  always_comb begin
    be_ok = bus.req_be inside {4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    dec = !be_ok ? 3'b000 :
          bus.req_addr < DM_LIMIT ? 3'b001 :
          (bus.req_addr >= DEV0_BASE && bus.req_addr < DEV0_BASE + 32'd12) ? 3'b010 :
          (bus.req_addr >= DEV1_BASE && bus.req_addr < DEV1_BASE + 32'd12) ? 3'b100 : 3'b000;
    fire = |(tgt_valid_q & bus.tgt_ready);
    accept = bus.req_valid && (state_q == EMPTY || fire);
    load = accept && |dec;
    state_d = load ? FULL : fire ? EMPTY : state_q;
    tgt_valid_d = load ? dec : fire ? 3'b000 : tgt_valid_q;
    addr_d = load ? bus.req_addr : addr_q;
    wdata_d = load ? bus.req_wdata : wdata_q;
    be_d = load ? bus.req_be : be_q;
    err_pulse_d = accept && !(|dec);
    err_addr_d = err_pulse_d ? bus.req_addr : err_addr_q;
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q     <= EMPTY;
      tgt_valid_q <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      err_pulse_q <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      tgt_valid_q <= tgt_valid_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      err_pulse_q <= err_pulse_d;
      err_addr_q  <= err_addr_d;
    end
  assign bus.req_ready = state_q == EMPTY || fire;
  assign bus.tgt_valid = tgt_valid_q;
  assign bus.tgt_addr  = addr_q;
  assign bus.tgt_wdata = wdata_q;
  assign bus.tgt_be    = be_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_addr  = err_addr_q;
`ifdef STORE_ROUTER_ERRCNT_EN
  logic [7:0] err_count_q, err_count_d;
  always_comb err_count_d = err_pulse_d && err_count_q != 8'hFF ? err_count_q + 8'd1 : err_count_q;
  always_ff @(posedge clk)
    if (reset) err_count_q <= '0;
    else err_count_q <= err_count_d;
  assign bus.err_count = err_count_q;
`else
  assign bus.err_count = 8'h00;
`endif
endmodule

// File: tb/tb_store_router.sv
// tb_store_router: directed and random stores checked against a queue-free behavioural model of the router
module tb_store_router;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  bit          m_full;
  int          m_tgt;
  logic [31:0] m_addr, m_wdata, m_err_addr;
  logic [3:0]  m_be;
  bit          m_errp;
  int          m_cnt;
  store_router_if bus ();
  store_router dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  function automatic int decode(input logic [31:0] a, input logic [3:0] be);
    if (!(be == 4'hF || be == 4'h3 || be == 4'hC || be == 4'h1 || be == 4'h2 || be == 4'h4 || be == 4'h8)) return -1;
    if (a < 32'h3000) return 0;
    if (a >= 32'h7F00 && a < 32'h7F0C) return 1;
    if (a >= 32'h7F10 && a < 32'h7F1C) return 2;
    return -1;
  endfunction
  task automatic model_reset();
    m_full = 0; m_tgt = 0; m_addr = 0; m_wdata = 0; m_be = 0;
    m_errp = 0; m_err_addr = 0; m_cnt = 0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.req_valid = 1'b0;
    bus.tgt_ready = 3'b000;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    chk("rst_tgt_valid", {29'b0, bus.tgt_valid}, 0);
    chk("rst_tgt_addr", bus.tgt_addr, 0);
    chk("rst_tgt_wdata", bus.tgt_wdata, 0);
    chk("rst_tgt_be", {28'b0, bus.tgt_be}, 0);
    chk("rst_err_pulse", {31'b0, bus.err_pulse}, 0);
    chk("rst_err_addr", bus.err_addr, 0);
    chk("rst_err_count", {24'b0, bus.err_count}, 0);
    chk("rst_req_ready", {31'b0, bus.req_ready}, 1);
  endtask
  task automatic cyc(input bit v, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be, input logic [2:0] rdy);
    logic [2:0] ev;
    bit rdy_exp, fire, acc;
    int t;
    @(negedge clk);
    bus.req_valid = v;
    bus.req_addr = a;
    bus.req_wdata = d;
    bus.req_be = be;
    bus.tgt_ready = rdy;
    #1;
    ev = m_full ? 3'(1 << m_tgt) : 3'b000;
    fire = m_full && rdy[m_tgt];
    rdy_exp = !m_full || fire;
    chk("tgt_valid", {29'b0, bus.tgt_valid}, {29'b0, ev});
    if (m_full) begin
      chk("tgt_addr", bus.tgt_addr, m_addr);
      chk("tgt_wdata", bus.tgt_wdata, m_wdata);
      chk("tgt_be", {28'b0, bus.tgt_be}, {28'b0, m_be});
    end
    chk("req_ready", {31'b0, bus.req_ready}, {31'b0, rdy_exp});
    chk("err_pulse", {31'b0, bus.err_pulse}, {31'b0, m_errp});
    chk("err_addr", bus.err_addr, m_err_addr);
`ifdef STORE_ROUTER_ERRCNT_EN
    chk("err_count", {24'b0, bus.err_count}, m_cnt);
`else
    chk("err_count", {24'b0, bus.err_count}, 0);
`endif
    acc = v && rdy_exp;
    t = decode(a, be);
    if (acc && t >= 0) begin
      m_full = 1; m_tgt = t; m_addr = a; m_wdata = d; m_be = be;
    end else if (fire) m_full = 0;
    m_errp = acc && t < 0;
    if (m_errp) begin
      m_err_addr = a;
      if (m_cnt < 255) m_cnt++;
    end
  endtask
  initial begin
    logic [31:0] a;
    logic [3:0] be;
    bus.req_valid = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.req_be = '0;
    bus.tgt_ready = '0;
    model_reset();
    do_reset();
    cyc(1, 32'h10, 32'h1234_5678, 4'hF, 3'b111);
    cyc(0, 32'h0, 32'h0, 4'h0, 3'b111);
    cyc(0, 32'h0, 32'h0, 4'h0, 3'b111);
    cyc(1, 32'h7F04, 32'hCAFE_0001, 4'hF, 3'b101);
    for (int i = 0; i < 3; i++) cyc(1, 32'h0, 32'h5555_5555, 4'hF, 3'b101);
    cyc(0, 32'h0, 32'h0, 4'h0, 3'b111);
    cyc(0, 32'h0, 32'h0, 4'h0, 3'b111);
    cyc(1, 32'h7F10, 32'hA1, 4'h3, 3'b111);
    cyc(1, 32'h2FFC, 32'hA2, 4'hC, 3'b111);
    cyc(1, 32'h7F08, 32'hA3, 4'h1, 3'b111);
    cyc(0, 32'h0, 32'h0, 4'h0, 3'b111);
    cyc(0, 32'h0, 32'h0, 4'h0, 3'b111);
    cyc(1, 32'h3000, 32'hB1, 4'hF, 3'b111);
    cyc(1, 32'h40, 32'hB2, 4'b0110, 3'b111);
    cyc(0, 32'h0, 32'h0, 4'h0, 3'b111);
    cyc(0, 32'h0, 32'h0, 4'h0, 3'b111);
    cyc(1, 32'h7F0C, 32'hB3, 4'hF, 3'b111);
    cyc(1, 32'h7F1C, 32'hB4, 4'h8, 3'b111);
    cyc(1, 32'h44, 32'hB5, 4'h0, 3'b111);
    cyc(0, 32'h0, 32'h0, 4'h0, 3'b111);
`ifdef STORE_ROUTER_ERRCNT_EN
    for (int i = 0; i < 300; i++) cyc(1, 32'h8000 + i, 32'h0, 4'hF, 3'b111);
    cyc(0, 32'h0, 32'h0, 4'h0, 3'b111);
`endif
    cyc(1, 32'h20, 32'hDEAD_BEEF, 4'hF, 3'b110);
    cyc(1, 32'h24, 32'h0, 4'hF, 3'b110);
    do_reset();
    cyc(0, 32'h0, 32'h0, 4'h0, 3'b111);
    cyc(1, 32'h7F14, 32'h0BAD_F00D, 4'h2, 3'b111);
    cyc(0, 32'h0, 32'h0, 4'h0, 3'b111);
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 4))
        0: a = $urandom_range(0, 32'h2FFF);
        1: a = 32'h7F00 + $urandom_range(0, 15);
        2: a = 32'h7F10 + $urandom_range(0, 15);
        3: a = $urandom;
        default: a = 32'h2FF0 + $urandom_range(0, 31);
      endcase
      be = $urandom_range(0, 1) ? 4'hF : 4'($urandom_range(0, 15));
      cyc(1'($urandom_range(0, 3) != 0), a, $urandom, be, 3'($urandom_range(0, 7)));
    end
    cyc(0, 32'h0, 32'h0, 4'h0, 3'b111);
    cyc(0, 32'h0, 32'h0, 4'h0, 3'b111);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/store_router.md
# store_router

Registered one-to-three write demultiplexer on the CPU store path: accepts one store request per handshake, decodes the address, and presents it to exactly one target (data memory, timer device 0, timer device 1) until that target accepts. Unmapped stores and illegal byte-enable patterns are dropped and flagged. Sits between the MEM-stage store datapath and the memory and peripheral write ports; it drives the store toward the targets, the reverse of the result-select muxes on the read side.

## Interface
- DM_LIMIT, 32'h0000_3000: data-memory window is [0, DM_LIMIT)
- DEV0_BASE, 32'h0000_7F00: timer 0 window, 12 bytes, [DEV0_BASE, DEV0_BASE+12)
- DEV1_BASE, 32'h0000_7F10: timer 1 window, 12 bytes, [DEV1_BASE, DEV1_BASE+12)
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  store request present
- req_ready  output  1  router can take a request this cycle
- req_addr  input  32  byte address
- req_wdata  input  32  store data, already lane-aligned
- req_be  input  4  byte enables
- tgt_valid  output  3  one-hot; bit0 DM, bit1 DEV0, bit2 DEV1
- tgt_ready  input  3  per-target accept
- tgt_addr  output  32  buffered address (shared by all targets)
- tgt_wdata  output  32  buffered data (shared)
- tgt_be  output  4  buffered byte enables (shared)
- err_pulse  output  1  one-cycle flag: a store was dropped
- err_addr  output  32  address of the most recent dropped store
- err_count  output  8  saturating drop count (only with macro, see Configuration)

## Operation
- Single-entry output buffer. FSM states: EMPTY, FULL.
- Request accepted when req_valid && req_ready. req_ready = (state==EMPTY) || (target fire this cycle). Fire = |(tgt_valid & tgt_ready).
- Decode on acceptance, in priority order: illegal be -> ERR; addr < DM_LIMIT -> DM; DEV0 window -> DEV0; DEV1 window -> DEV1; otherwise ERR.
- Legal be: 4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000. All others, including 4'b0000, are illegal.
- Legal accept: buffer captures addr/wdata/be and the one-hot target. Next state FULL.
- ERR accept: nothing buffered, so state is unchanged. err_pulse=1 next cycle; err_addr<=req_addr.
- EMPTY: tgt_valid=3'b000.
- FULL: tgt_valid holds the captured one-hot. tgt_addr, tgt_wdata and tgt_be stay stable until fire.
- FULL + fire + no new legal accept -> EMPTY.
- FULL + fire + simultaneous legal accept -> stays FULL with the new entry. No bubble.
- tgt_ready bits for non-selected targets are ignored.
- tgt_addr, tgt_wdata and tgt_be hold their last value when EMPTY. They are valid only while tgt_valid is nonzero.

## Timing
- Reset values: state EMPTY, tgt_valid 0, tgt_addr/tgt_wdata/tgt_be 0, err_pulse 0, err_addr 0, err_count 0. req_ready is therefore 1 in the cycle after reset.
- Latency: a request accepted at edge N drives tgt_valid from cycle N+1. With tgt_ready held high, throughput is one store per cycle.
- err_pulse is high for exactly one cycle after each dropped store. Back-to-back drops keep it high on consecutive cycles.
- Reset asserted while FULL discards the buffered store. It is never presented again.
- req_ready depends combinationally on tgt_ready. tgt_valid depends only on registered state.

## Configuration
- STORE_ROUTER_ERRCNT_EN defined:
  - err_count increments on each dropped store and saturates at 8'hFF.
  - Reset clears it.
  - ERR-accept and reset in the same cycle: reset wins.
- STORE_ROUTER_ERRCNT_EN undefined:
  - No counter logic is built; err_count is tied to 8'h00.
  - err_pulse and err_addr are unaffected.

## Test plan
- Reset, then store addr 0x0000_0010, be 4'hF, data 0x1234_5678, tgt_ready 3'b111 -> tgt_valid 3'b001 for one cycle; tgt_wdata 0x1234_5678; req_ready stays 1.
- Store to 0x0000_7F04 with tgt_ready[1]=0 for 3 cycles, then 1 -> tgt_valid 3'b010 held 4 cycles with stable address and data; req_ready 0 during the stall and 1 in the fire cycle.
- Back-to-back stores to 0x7F10, 0x0000_2FFC, 0x7F08, all ready -> tgt_valid 3'b100, 3'b001, 3'b010 on consecutive cycles with no bubble.
- Store to 0x0000_3000, then a store with be 4'b0110 -> two err_pulse cycles; err_addr ends at the second address; tgt_valid stays 0; err_count=2 with the macro, 0 without.
- 300 unmapped stores with STORE_ROUTER_ERRCNT_EN -> err_count saturates at 8'hFF.
- Hold DM ready low, accept a store, assert reset for one cycle -> tgt_valid 0 after reset and all outputs at reset values; a new store proceeds normally.
